// File: rtl/axi_aw_alloc_pkg.sv
// Shared types and helpers for the AXI AW round-robin allocator.
package axi_aw_alloc_pkg;

  typedef enum logic {ARB, LOCKED} aw_alloc_state_t;

  // Computes (base + off) mod n, where base < n and off <= n. A subtract replaces the divider.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/axi_aw_order_fifo.sv
// Grant-order FIFO: remembers which master won each AW handshake so that W bursts
// are forwarded in the same order. The head is forced to 0 while the FIFO is empty.
module axi_aw_order_fifo #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Full and empty come straight from the registered count.
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // A pop on an empty FIFO is dropped; the allocator never pushes while full.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & ~o_full;

  // Storage write.
  // NOTE: the storage array has no reset; only pointers and count do, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy count.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Popping an empty FIFO is tolerated but flagged; pushing while full is a design error.
  a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(i_pop && o_empty))
    else $warning("pop request ignored, order FIFO empty");
  a_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full));

endmodule

// File: rtl/axi_aw_rr_allocator.sv
// Round-robin AW arbiter: shares one slave AW channel among N_TARG_PORT masters,
// holds the winner stable until the handshake, and records grant order for the W mux.
module axi_aw_rr_allocator
  import axi_aw_alloc_pkg::*;
#(
  parameter int N_TARG_PORT = 8,
  parameter int PAYLOAD_W   = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [N_TARG_PORT-1:0]             awvalid_i,
  input  logic [N_TARG_PORT*PAYLOAD_W-1:0]   awdata_i,
  output logic [N_TARG_PORT-1:0]             awready_o,
  output logic                               awvalid_o,
  output logic [PAYLOAD_W-1:0]               awdata_o,
  output logic [$clog2(N_TARG_PORT)-1:0]     awsrc_o,
  input  logic                               awready_i,
  output logic [$clog2(N_TARG_PORT)-1:0]     w_sel_o,
  output logic                               w_sel_valid_o,
  input  logic                               w_last_done_i
);

  localparam int LOG_N = $clog2(N_TARG_PORT);

  aw_alloc_state_t  r_state;
  aw_alloc_state_t  w_next_state;
  logic [LOG_N-1:0] r_ptr;
  logic [LOG_N-1:0] r_winner;
  logic [LOG_N-1:0] w_idx;
  logic [LOG_N-1:0] w_scan;
  logic             w_found;
  logic [LOG_N-1:0] w_win;
  logic             w_grant_valid;
  logic             w_push;
  logic             w_full;
  logic             w_empty;

  // Priority scan starting just after the last winner, wrapping modulo N_TARG_PORT.
  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    w_found = 1'b0;
    w_scan  = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_TARG_PORT; k++) begin
      w_idx = LOG_N'(wrap_add(int'(r_ptr), k, N_TARG_PORT));
      if (!w_found && awvalid_i[w_idx]) begin
        w_found = 1'b1;
        w_scan  = w_idx;
      end
    end
  end

  // Next-state and grant decode: ARB arbitrates live, LOCKED replays the held winner.
  always_comb begin
    w_next_state  = r_state;
    w_win         = '0;
    w_grant_valid = 1'b0;
    w_push        = 1'b0;
    case (r_state)
      ARB: begin
        if (w_found && !w_full) begin
          w_grant_valid = 1'b1;
          w_win         = w_scan;
          if (awready_i) w_push = 1'b1;
          else           w_next_state = LOCKED;
        end
      end
      LOCKED: begin
        w_grant_valid = 1'b1;
        w_win         = r_winner;
        if (awready_i) begin
          w_push       = 1'b1;
          w_next_state = ARB;
        end
      end
      default: w_next_state = ARB;
    endcase
  end

  // Slave-side outputs; the payload mux is zeroed when no grant is offered.
  always_comb begin
    awvalid_o = w_grant_valid;
    awsrc_o   = w_win;
    awdata_o  = w_grant_valid ? awdata_i[int'(w_win)*PAYLOAD_W +: PAYLOAD_W] : '0;
    awready_o = w_push ? (N_TARG_PORT'(1) << w_win) : '0;
  end

  // FSM state, round-robin pointer and held winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB;
      r_ptr    <= LOG_N'(N_TARG_PORT - 1);
      r_winner <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_push) r_ptr <= w_win;
      if (r_state == ARB && w_next_state == LOCKED) r_winner <= w_win;
    end
  end

  axi_aw_order_fifo #(
    .DATA_W (LOG_N),
    .DEPTH  (FIFO_DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_win),
    .i_pop   (w_last_done_i),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_sel_o)
  );

  assign w_sel_valid_o = ~w_empty;

  // AXI stability of an offered but not yet accepted address, and grant shape.
  a_aw_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (awvalid_o && !awready_i) |=> (awvalid_o && $stable(awdata_o) && $stable(awsrc_o)));
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(awready_o));
  a_ready_qual: assert property (@(posedge clk) disable iff (!rst_n)
    (awready_o != '0) |-> (awvalid_o && awready_i));

endmodule
